// File: rtl/mult_booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   MULT_WIDTH   default operand width
//   mb_state_e   FSM encodings (IDLE=0, CALC=1, DONE=2); the control unit's
//                HI/LO sequencing uses these same encodings
//   booth_op_e   per-iteration action chosen from {Q[0], Q_-1}
//   booth_decode maps the two recoding bits to an action
package mult_booth_pkg;

  localparam int unsigned MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_CALC = 2'd1,
    MB_DONE = 2'd2
  } mb_state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_e;

  // 01 -> add M, 10 -> subtract M, 00/11 -> run of equal bits, no change
  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    booth_op_e op;
    case ({q0, q_m1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mult_booth_if.sv
// Handshake/data bundle between the multicycle control unit and the Booth
// multiplier.
//   start         pulse to begin a multiply (sampled in IDLE only)
//   a_in / b_in   signed multiplicand / multiplier, sampled with start
//   busy          multiplier is in CALC or DONE
//   done          one-cycle pulse, hi_out/lo_out hold the new product
//   hi_out/lo_out upper/lower halves of the 2*WIDTH product
// master: control unit side; slave: multiplier side.
interface mult_booth_if
  import mult_booth_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, a_in, b_in,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/mult_booth_step.sv
// One combinational radix-2 Booth iteration: optional add/subtract of M into
// the accumulator, then an arithmetic right shift of {acc, Q, Q_-1}.
//   acc       (WIDTH+1) current accumulator
//   q         (WIDTH)   current multiplier/low-product register
//   q_m1      (1)       bit shifted out of Q on the previous iteration
//   m         (WIDTH+1) sign-extended multiplicand
//   acc_next, q_next, q_m1_next  register values after this iteration
module booth_step
  import mult_booth_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  // Add/subtract selected by the recoding bits
  always_comb begin
    sum = acc;
    case (booth_decode(q[0], q_m1))
      OP_ADD:  sum = acc + m;
      OP_SUB:  sum = acc - m;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift right of {sum, q, q_m1}, replicating the sum MSB
  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH,
// WIDTH iterations per product; sits downstream of the multicycle control unit.
//   clk    system clock
//   reset  asynchronous, active-high; clears all state
//   bus    mult_booth_if slave: start/a_in/b_in in; busy/done/hi_out/lo_out out
// busy is decoded from state; done, hi_out and lo_out are registered.
module mult_booth
  import mult_booth_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input logic           clk,
  input logic           reset,
  mult_booth_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  mb_state_e        state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   m;
  logic [CNT_W-1:0] count;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;
  logic             q_m1_next;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .m         (m),
    .acc_next  (acc_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  // FSM, datapath registers and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MB_IDLE;
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      m      <= '0;
      count  <= '0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        MB_IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            // Extra sign bit keeps acc - M exact when a_in is the most negative value
            m     <= {bus.a_in[WIDTH-1], bus.a_in};
            q     <= bus.b_in;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= CNT_W'(WIDTH);
            state <= MB_CALC;
          end
        end
        MB_CALC: begin
          acc   <= acc_next;
          q     <= q_next;
          q_m1  <= q_m1_next;
          count <= count - CNT_W'(1);
          // Last iteration: publish the post-shift product alongside the step
          if (count == CNT_W'(1)) begin
            hi_out <= acc_next[WIDTH-1:0];
            lo_out <= q_next;
            done   <= 1'b1;
            state  <= MB_DONE;
          end
        end
        MB_DONE: begin
          done  <= 1'b0;
          state <= MB_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= MB_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state != MB_IDLE);
  assign bus.done   = done;
  assign bus.hi_out = hi_out;
  assign bus.lo_out = lo_out;

endmodule

// File: tb/tb_mult_booth.sv
// Directed bench for mult_booth: reset state, latency, signed corner
// products, busy protocol, back-to-back start, async abort, random pairs.
module tb_mult_booth;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mult_booth_if #(.WIDTH(W)) bus ();

  mult_booth #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; returns at the negedge after that edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Bounded wait for the done pulse, sampled on negedges
  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    start_op(a, b);
    wait_done(tag);
    chk({tag, "_hi"}, 64'(bus.hi_out), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo_out), 64'(exp_lo));
  endtask

  initial begin
    int pulses;
    logic [W-1:0] cap_hi;
    logic [W-1:0] cap_lo;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    longint prod;

    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi_out), 64'd0);
    chk("rst_lo", 64'(bus.lo_out), 64'd0);
    reset = 1'b0;

    // 3*5 with exact latency: done appears only after the 32nd edge past the start edge
    start_op(32'd3, 32'd5);
    chk("lat_busy_k0", 64'(bus.busy), 64'd1);
    repeat (31) @(negedge clk);
    chk("lat_done_k31", 64'(bus.done), 64'd0);
    @(negedge clk);
    chk("lat_done_k32", 64'(bus.done), 64'd1);
    chk("lat_hi", 64'(bus.hi_out), 64'h0);
    chk("lat_lo", 64'(bus.lo_out), 64'hF);
    @(negedge clk);
    chk("lat_done_pulse_end", 64'(bus.done), 64'd0);
    chk("lat_busy_end", 64'(bus.busy), 64'd0);
    chk("lat_hold_lo", 64'(bus.lo_out), 64'hF);

    // Signed corner vectors
    run_and_check("m7x6", 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_and_check("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_and_check("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    run_and_check("minxmax", 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000);

    // Busy protocol: second start during CALC is ignored
    start_op(32'd2, 32'd3);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 32'd9;
    bus.b_in  = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    cap_hi = '1;
    cap_lo = '1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        cap_hi = bus.hi_out;
        cap_lo = bus.lo_out;
      end
      @(negedge clk);
    end
    chk("busy_pulses", 64'(pulses), 64'd1);
    chk("busy_hi", 64'(cap_hi), 64'd0);
    chk("busy_lo", 64'(cap_lo), 64'd6);
    chk("busy_idle_after", 64'(bus.busy), 64'd0);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 32'd2;
    bus.b_in  = 32'd7;
    @(negedge clk);
    wait_done("b2b1");
    chk("b2b1_hi", 64'(bus.hi_out), 64'd0);
    chk("b2b1_lo", 64'(bus.lo_out), 64'd14);
    bus.a_in = 32'hFFFF_FFFD;
    bus.b_in = 32'd4;
    @(negedge clk);
    chk("b2b_idle_gap_busy", 64'(bus.busy), 64'd0);
    chk("b2b_idle_gap_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    chk("b2b_accept_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    bus.a_in  = 32'h1234_5678;
    bus.b_in  = 32'h8765_4321;
    wait_done("b2b2");
    chk("b2b2_hi", 64'(bus.hi_out), 64'hFFFF_FFFF);
    chk("b2b2_lo", 64'(bus.lo_out), 64'hFFFF_FFF4);

    // Async reset in the middle of 4*4
    start_op(32'd4, 32'd4);
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hi", 64'(bus.hi_out), 64'd0);
    chk("abort_lo", 64'(bus.lo_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    chk("abort_lo_stays0", 64'(bus.lo_out), 64'd0);

    // First op after reset
    run_and_check("one_x_m1", 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Random signed pairs against a 64-bit signed reference
    for (int n = 0; n < 6; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      prod = longint'($signed(ra)) * longint'($signed(rb));
      run_and_check($sformatf("rand%0d", n), ra, rb, prod[63:32], prod[31:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
